// File: rtl/fpu_types_pkg.sv
// Shared binary16 constants and types for the Zfh datapath.
// No logic; latency n/a.
// No handshake; backpressure n/a.
package fpu_types_pkg;

    localparam int HALF_FLOAT_W    = 16;
    localparam int HALF_EXPONENT_W = 5;
    localparam int HALF_FRACTION_W = 10;
    localparam int HALF_BIAS       = 15;

    localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO = 16'h0000;
    localparam logic [HALF_FLOAT_W-1:0] HALF_QNAN = 16'h7E00;
    localparam logic [HALF_FLOAT_W-1:0] HALF_INF  = 16'h7C00;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        ROUND,
        DONE
    } div_state_t;

endpackage

// File: rtl/zfh_classify.sv
// binary16 operand classifier; subnormals flush to zero.
// Combinational, zero latency.
// No handshake; backpressure n/a.
module zfh_classify
    import fpu_types_pkg::*;
(
    input  logic [HALF_FLOAT_W-1:0]    op_i,
    output logic                       is_zero_o,
    output logic                       is_inf_o,
    output logic                       is_snan_o,
    output logic                       is_qnan_o,
    output logic [HALF_FRACTION_W:0]   sig_o
);

    logic [HALF_EXPONENT_W-1:0] exp_w;
    logic [HALF_FRACTION_W-1:0] frac_w;
    logic                       exp_zero;
    logic                       exp_max;

    assign exp_w    = op_i[HALF_FLOAT_W-2 -: HALF_EXPONENT_W];
    assign frac_w   = op_i[HALF_FRACTION_W-1:0];
    assign exp_zero = (exp_w == '0);
    assign exp_max  = &exp_w;

    assign is_zero_o = exp_zero;
    assign is_inf_o  = exp_max && (frac_w == '0);
    assign is_qnan_o = exp_max && frac_w[HALF_FRACTION_W-1];
    assign is_snan_o = exp_max && !frac_w[HALF_FRACTION_W-1] && (frac_w != '0);
    assign sig_o     = exp_zero ? '0 : {1'b1, frac_w};

endmodule

// File: rtl/zfh_div_seq.sv
// Iterative binary16 divider, radix-2 restoring, RNE, RISC-V fflags.
// Latency: UNPACK + QBITS divide cycles + ROUND before DONE; specials skip straight to DONE.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module zfh_div_seq
    import fpu_types_pkg::*;
#(
    parameter int QBITS = 14
)(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [4:0]  fflags
);

    div_state_t        state_q, state_d;
    logic [15:0]       a_q, a_d, b_q, b_d;
    logic              sign_q, sign_d;
    logic [6:0]        exp_q, exp_d;
    logic [11:0]       rem_q, rem_d;
    logic [10:0]       mb_q, mb_d;
    logic [QBITS-1:0]  quo_q, quo_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       res_q, res_d;
    fflags_t           flg_q, flg_d;

    logic        a_zero, a_inf, a_snan, a_qnan;
    logic        b_zero, b_inf, b_snan, b_qnan;
    logic [10:0] a_sig, b_sig;

    zfh_classify u_cls_a (
        .op_i      (a_q),
        .is_zero_o (a_zero),
        .is_inf_o  (a_inf),
        .is_snan_o (a_snan),
        .is_qnan_o (a_qnan),
        .sig_o     (a_sig)
    );

    zfh_classify u_cls_b (
        .op_i      (b_q),
        .is_zero_o (b_zero),
        .is_inf_o  (b_inf),
        .is_snan_o (b_snan),
        .is_qnan_o (b_qnan),
        .sig_o     (b_sig)
    );

    // Normalize / round datapath, consumed only in ROUND.
    logic [QBITS-1:0] qn;
    logic [6:0]       en, er;
    logic [10:0]      sig_n;
    logic [9:0]       sig_r;
    logic [11:0]      sum;
    logic             g, st, inc;

    always_comb begin
        qn    = quo_q[QBITS-1] ? quo_q : (quo_q << 1);
        en    = quo_q[QBITS-1] ? exp_q : (exp_q - 7'd1);
        sig_n = qn[QBITS-1 -: 11];
        g     = qn[QBITS-12];
        st    = (|qn[QBITS-13:0]) | (|rem_q);
        inc   = g & (st | sig_n[0]);
        sum   = {1'b0, sig_n} + {11'b0, inc};
        sig_r = sum[11] ? sum[10:1] : sum[9:0];
        er    = sum[11] ? (en + 7'd1) : en;
    end

    logic [11:0] diff;
    logic        ge;
    logic        sgn;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        mb_d     = mb_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        flg_d    = flg_q;
        in_ready = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sgn      = a_q[15] ^ b_q[15];
        ge       = (rem_q >= {1'b0, mb_q});
        diff     = ge ? (rem_q - {1'b0, mb_q}) : rem_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d  = sgn;
                flg_d   = '0;
                state_d = DONE;
                if (a_snan || b_snan) begin
                    res_d    = HALF_QNAN;
                    flg_d.nv = 1'b1;
                end else if (a_qnan || b_qnan) begin
                    res_d = HALF_QNAN;
                end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
                    res_d    = HALF_QNAN;
                    flg_d.nv = 1'b1;
                end else if (b_zero) begin
                    res_d    = {sgn, HALF_INF[14:0]};
                    flg_d.dz = 1'b1;
                end else if (a_inf) begin
                    res_d = {sgn, HALF_INF[14:0]};
                end else if (a_zero || b_inf) begin
                    res_d = {sgn, HALF_ZERO[14:0]};
                end else begin
                    rem_d   = {1'b0, a_sig};
                    mb_d    = b_sig;
                    quo_d   = '0;
                    exp_d   = {2'b0, a_q[14:10]} - {2'b0, b_q[14:10]} + 7'(HALF_BIAS);
                    cnt_d   = 4'(QBITS - 1);
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                // Compare before doubling so quo = floor(ma * 2^(QBITS-1) / mb), MSB is the integer bit.
                quo_d = {quo_q[QBITS-2:0], ge};
                rem_d = diff << 1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                flg_d   = '0;
                state_d = DONE;
                if ($signed(er) >= 7'sd31) begin
                    res_d    = {sign_q, HALF_INF[14:0]};
                    flg_d.of = 1'b1;
                    flg_d.nx = 1'b1;
                end else if ($signed(er) <= 7'sd0) begin
                    res_d    = {sign_q, HALF_ZERO[14:0]};
                    flg_d.uf = 1'b1;
                    flg_d.nx = 1'b1;
                end else begin
                    res_d    = {sign_q, er[4:0], sig_r};
                    flg_d.nx = g | st;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            mb_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= HALF_ZERO;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            mb_q    <= mb_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign quotient = res_q;
    assign fflags   = flg_q;

endmodule

// File: tb/tb_zfh_div_seq.sv
// Scoreboard bench for zfh_div_seq: directed vectors, decoupled monitor.
module tb_zfh_div_seq;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] quotient;
    logic [4:0]  fflags;

    zfh_div_seq dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .fflags    (fflags)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [4:0]  f;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   ncmp = 0;
    int   nbad = 0;
    bit   vld_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Latency counts rising edges inclusive of the accept edge up to the one that raises out_valid.
    always @(negedge CLK) begin
        if (!nRST) begin
            vld_seen = 0;
        end else if (out_valid && !vld_seen) begin
            vld_seen = 1;
            if (sb.size() == 0) begin
                ncmp++;
                nbad++;
                $display("FAIL unexpected_result: got %h with no pending request", quotient);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.nm, "_quotient"}, 32'(quotient), 32'(mon_e.q));
                check({mon_e.nm, "_fflags"}, 32'(fflags), 32'(mon_e.f));
                check({mon_e.nm, "_latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end else if (!out_valid) begin
            vld_seen = 0;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                         input logic [4:0] f, input int lat, input string nm, input bit push);
        int n;
        n = 0;
        @(negedge CLK);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            ncmp++;
            nbad++;
            $display("FAIL %s_accept: in_ready stayed 0, expected 1", nm);
            in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        if (push) sb.push_back('{q: q, f: f, lat: lat, acc: cyc, nm: nm});
    endtask

    task automatic wait_vld(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!out_valid) begin
            ncmp++;
            nbad++;
            $display("FAIL %s_timeout: out_valid 0 after 40 cycles, expected 1", nm);
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                       input logic [4:0] f, input int lat, input string nm);
        issue(a, b, q, f, lat, nm, 1'b1);
        wait_vld(nm);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #7;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_quotient", 32'(quotient), 32'h0000);
        check("reset_fflags", 32'(fflags), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        run(16'h3C00, 16'h4000, 16'h3800, 5'b00000, 17, "one_div_two");
        run(16'h4200, 16'h4000, 16'h3E00, 5'b00000, 17, "three_div_two");
        run(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 17, "one_div_three");
        run(16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 2,  "div_by_zero");
        run(16'h0000, 16'h0000, 16'h7E00, 5'b10000, 2,  "zero_div_zero");
        run(16'h7C01, 16'h3C00, 16'h7E00, 5'b10000, 2,  "snan");
        run(16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 2,  "neg_inf");
        run(16'h7BFF, 16'h0400, 16'h7C00, 5'b00101, 17, "overflow");
        run(16'h0400, 16'h7BFF, 16'h0000, 5'b00011, 17, "underflow");
        run(16'h8400, 16'h7BFF, 16'h8000, 5'b00011, 17, "neg_underflow");

        // Hold the result in DONE while a competing request is offered.
        out_ready = 1'b0;
        issue(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 17, "bp", 1'b1);
        wait_vld("bp");
        @(negedge CLK);
        dividend = 16'h4400;
        divisor  = 16'h4000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_hold_quotient", 32'(quotient), 32'h3555);
            check("bp_hold_fflags", 32'(fflags), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Abort mid-divide: seven edges after accept the counter sits at 7.
        issue(16'h3C00, 16'h4000, 16'h3800, 5'b00000, 17, "aborted", 1'b0);
        repeat (7) @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_quotient", 32'(quotient), 32'h0000);
        @(negedge CLK);
        nRST = 1'b1;
        run(16'h4400, 16'h4000, 16'h4000, 5'b00000, 17, "after_abort");

        repeat (20) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
